write_back: RTL and testbench
=============================

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 SHALL have ports clock, reset; one clock; reset is asynchronous and active-high.
REQ-002 clock  in  1  stage clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 is_valid  in  1  execute stage presents a valid instruction.
REQ-005 hold  out  1  stall request to execute; execute keeps its outputs while high.
REQ-006 pc  in  32  pc of the presented instruction.
REQ-007 target_register  in  5  destination register index, or address register when is_writing_memory.
REQ-008 is_writing_memory  in  1  instruction is a store.
REQ-009 flags  in  4  {carry, negative, overflow, zero}.
REQ-010 target_value  in  32  result value, or store base address.
REQ-011 has_upper_value / upper_value  in  1 / 32  upper half of multiply/divide result.
REQ-012 adjustment_value  in  32  store offset.
REQ-013 has_flushed  in  1  instruction is squashed; no architectural effect.
REQ-014 registers  out  32x32  register file contents (regfile_t), fed back to read and execute.
REQ-015 mem_write / mem_address / mem_data  out  1 / 32 / 32  store request.
REQ-016 mem_ready  in  1  memory accepts the store in the cycle it is high with mem_write.
REQ-017 retired / retired_pc  out  1 / 32  one-cycle pulse and pc on instruction completion.

Function
REQ-018 An instruction is accepted when is_valid is high, hold is low and state is IDLE.
REQ-019 Accepted, not flushed, not store: registers[target_register] <= target_value; registers[FLAGS_INDEX][31:28] <= flags; retired is pulsed on the next cycle; latency 1.
REQ-020 Writes to register 0 are dropped; register 0 always reads 0.
REQ-021 If target_register == FLAGS_INDEX, target_value wins over the flags update.
REQ-022 States: IDLE, UPPER, STORE.
REQ-023 Accepted with has_upper_value: low write as in REQ-019, IDLE->UPPER, hold high.
REQ-024 In UPPER: registers[(target_register+1) mod 32] <= upper_value, with index 0 dropped; retired pulses; UPPER->IDLE.
REQ-025 Accepted store: mem_address = target_value + adjustment_value (mod 2^32); mem_data = registers[target_register] sampled at acceptance; mem_write high; IDLE->STORE; no register or flags write.
REQ-026 In STORE: mem_write, mem_address and mem_data stay stable and hold is high until mem_ready; on mem_ready, mem_write drops next cycle, retired pulses, STORE->IDLE.
REQ-027 mem_ready in the first STORE cycle SHALL complete the store in that cycle; total latency is 2 cycles.
REQ-028 hold = (state != IDLE) && is_valid.
REQ-029 Accepted with has_flushed: no register, flags or memory effect, no retired pulse, stays IDLE.
REQ-030 is_valid low: no state change, no writes.
REQ-031 Captured instruction fields are registered at acceptance; input changes during UPPER/STORE are ignored.

Reset
REQ-032 reset SHALL immediately clear all registers to 0, state to IDLE, and mem_write, retired, retired_pc, mem_address and mem_data to 0.
REQ-033 reset during STORE abandons the store with no retry; reset during UPPER drops the upper write.

Configuration
REQ-034 With WRITE_UPPER_EN defined: UPPER state and REQ-023/024 apply.
REQ-035 Without WRITE_UPPER_EN: no UPPER state; upper_value and has_upper_value are ignored; the instruction retires with latency 1.

Structure
REQ-036 Shared package SHALL hold regind_t, regval_t, regfile_t, FLAGS_INDEX and the state enum write_state_t.
REQ-037 The store handshake (REQ-025..027) SHALL be a sub-module write_store_port; the register file and FSM stay in write_back.

Verification
REQ-038 ALU write r5=0x12345678, flags=4'b1010 -> next cycle registers[5]=0x12345678, Flags[31:28]=1010, retired=1, retired_pc=pc.
REQ-039 Multiply with target_register=31, upper=0xFFFF0000, lo=0x1 (WRITE_UPPER_EN) -> r31=0x1, hold high 1 cycle, upper write to r0 dropped, r0=0.
REQ-040 Store base 0xFFFFFFFC + offset 8, r3=0xDEADBEEF, mem_ready low 3 cycles -> mem_address=0x4, mem_data=0xDEADBEEF stable, hold high until ready, one retired pulse.
REQ-041 has_flushed=1 on an ALU op and on a store -> no register change, mem_write stays 0, retired stays 0.
REQ-042 Assert reset mid-STORE -> mem_write=0 immediately, all registers 0, state IDLE, next instruction accepted normally.
REQ-043 target_register=FLAGS_INDEX with value 0x0 and flags=4'b1111 -> Flags register=0x0.

Source files
------------

// File: rtl/write_back_pkg.sv
// Shared types and constants for the write-back stage.
// Optional feature macro: WRITE_UPPER_EN (adds the UPPER state for
// two-register multiply/divide results).
package write_back_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0]                regind_t;
    typedef logic [31:0]               regval_t;
    typedef regval_t [NUM_REGS-1:0]    regfile_t;

    // Register whose top nibble holds {carry, negative, overflow, zero}.
    localparam regind_t FLAGS_INDEX = 5'd30;

`ifdef WRITE_UPPER_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UPPER = 2'd1,
        STORE = 2'd2
    } write_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd2
    } write_state_t;
`endif

endpackage

// File: rtl/write_store_port.sv
// Store handshake: latches address/data at start and holds the request
// stable until memory signals ready.
module write_store_port
    import write_back_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    start,
    input  regval_t base,
    input  regval_t offset,
    input  regval_t data,
    input  logic    mem_ready,
    output logic    mem_write,
    output regval_t mem_address,
    output regval_t mem_data,
    output logic    done
);

    logic    mem_write_reg;
    regval_t mem_address_reg;
    regval_t mem_data_reg;

    // The request completes in any cycle it is outstanding and memory is ready,
    // including the first one.
    assign done = mem_write_reg && mem_ready;

    // Launch a request on start, keep it stable, retire it on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
        end else if (start) begin
            mem_write_reg   <= 1'b1;
            mem_address_reg <= base + offset;
            mem_data_reg    <= data;
        end else if (done) begin
            mem_write_reg   <= 1'b0;
        end
    end

    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_data    = mem_data_reg;

endmodule

// File: rtl/write_back.sv
// Write-back stage: register file, flags update, optional upper-half write
// and store issue. Optional feature macro: WRITE_UPPER_EN.
module write_back
    import write_back_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        is_valid,
    output logic        hold,
    input  logic [31:0] pc,
    input  logic [4:0]  target_register,
    input  logic        is_writing_memory,
    input  logic [3:0]  flags,
    input  logic [31:0] target_value,
    input  logic        has_upper_value,
    input  logic [31:0] upper_value,
    input  logic [31:0] adjustment_value,
    input  logic        has_flushed,
    output regfile_t    registers,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic        retired,
    output logic [31:0] retired_pc
);

    write_state_t state_reg, state_next;

    logic        accept;
    logic        commit;
    logic        lo_en;
    logic        flags_en;
    logic        hi_en;
    regind_t     hi_idx;
    regval_t     hi_val;
    logic        store_start;
    logic        store_done;
    logic        retire_now;
    logic [31:0] retire_pc_now;

    logic [31:0] cap_pc_reg;
`ifdef WRITE_UPPER_EN
    regind_t     cap_index_reg;
    regval_t     cap_upper_reg;
`else
    // Upper result is not used when the UPPER path is compiled out.
    logic        unused_upper;
    assign unused_upper = ^{has_upper_value, upper_value};
`endif

    assign hold = (state_reg != IDLE) && is_valid;

    // Next-state and write-enable decode.
    always_comb begin
        state_next    = state_reg;
        accept        = is_valid && (state_reg == IDLE);
        commit        = accept && !has_flushed;
        lo_en         = commit && !is_writing_memory;
        flags_en      = lo_en;
        store_start   = commit && is_writing_memory;
        hi_en         = 1'b0;
        hi_idx        = '0;
        hi_val        = '0;
        retire_now    = 1'b0;
        retire_pc_now = pc;
        case (state_reg)
            IDLE: begin
                if (store_start) begin
                    state_next = STORE;
`ifdef WRITE_UPPER_EN
                end else if (lo_en && has_upper_value) begin
                    state_next = UPPER;
`endif
                end else if (lo_en) begin
                    retire_now = 1'b1;
                end
            end
`ifdef WRITE_UPPER_EN
            UPPER: begin
                hi_en         = 1'b1;
                hi_idx        = cap_index_reg + 5'd1;
                hi_val        = cap_upper_reg;
                retire_now    = 1'b1;
                retire_pc_now = cap_pc_reg;
                state_next    = IDLE;
            end
`endif
            STORE: begin
                if (store_done) begin
                    retire_now    = 1'b1;
                    retire_pc_now = cap_pc_reg;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction fields captured at acceptance for the multi-cycle paths.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_pc_reg    <= '0;
`ifdef WRITE_UPPER_EN
            cap_index_reg <= '0;
            cap_upper_reg <= '0;
`endif
        end else if (accept) begin
            cap_pc_reg    <= pc;
`ifdef WRITE_UPPER_EN
            cap_index_reg <= target_register;
            cap_upper_reg <= upper_value;
`endif
        end
    end

    // One-cycle retire pulse; retired_pc keeps the last retired pc.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired    <= 1'b0;
            retired_pc <= '0;
        end else begin
            retired <= retire_now;
            if (retire_now) begin
                retired_pc <= retire_pc_now;
            end
        end
    end

    // Register file: r0 is hard-wired zero; a direct write to the flags
    // register takes priority over the flags nibble update.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign registers[gi] = '0;
            end else begin : g_live
                regval_t value_reg;
                // Per-register write: low result, upper result, then flags.
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        value_reg <= '0;
                    end else if (lo_en && (target_register == regind_t'(gi))) begin
                        value_reg <= target_value;
                    end else if (hi_en && (hi_idx == regind_t'(gi))) begin
                        value_reg <= hi_val;
                    end else if (flags_en && (regind_t'(gi) == FLAGS_INDEX)) begin
                        value_reg[31:28] <= flags;
                    end
                end
                assign registers[gi] = value_reg;
            end
        end
    endgenerate

    write_store_port u_store (
        .clock       (clock),
        .reset       (reset),
        .start       (store_start),
        .base        (target_value),
        .offset      (adjustment_value),
        .data        (registers[target_register]),
        .mem_ready   (mem_ready),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .done        (store_done)
    );

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back.
module tb_write_back;
    import write_back_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        is_valid;
    logic        hold;
    logic [31:0] pc;
    logic [4:0]  target_register;
    logic        is_writing_memory;
    logic [3:0]  flags;
    logic [31:0] target_value;
    logic        has_upper_value;
    logic [31:0] upper_value;
    logic [31:0] adjustment_value;
    logic        has_flushed;
    regfile_t    registers;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        retired;
    logic [31:0] retired_pc;

    int tests = 0;
    int fails = 0;

    write_back dut (
        .clock             (clock),
        .reset             (reset),
        .is_valid          (is_valid),
        .hold              (hold),
        .pc                (pc),
        .target_register   (target_register),
        .is_writing_memory (is_writing_memory),
        .flags             (flags),
        .target_value      (target_value),
        .has_upper_value   (has_upper_value),
        .upper_value       (upper_value),
        .adjustment_value  (adjustment_value),
        .has_flushed       (has_flushed),
        .registers         (registers),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .mem_ready         (mem_ready),
        .retired           (retired),
        .retired_pc        (retired_pc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        is_valid          = 1'b0;
        pc                = '0;
        target_register   = '0;
        is_writing_memory = 1'b0;
        flags             = '0;
        target_value      = '0;
        has_upper_value   = 1'b0;
        upper_value       = '0;
        adjustment_value  = '0;
        has_flushed       = 1'b0;
        mem_ready         = 1'b0;
    endtask

    task automatic alu(input logic [31:0] p, input logic [4:0] r,
                       input logic [31:0] v, input logic [3:0] f);
        idle_inputs();
        is_valid = 1'b1; pc = p; target_register = r; target_value = v; flags = f;
    endtask

    task automatic store(input logic [31:0] p, input logic [4:0] r,
                         input logic [31:0] base, input logic [31:0] off);
        idle_inputs();
        is_valid = 1'b1; pc = p; target_register = r; is_writing_memory = 1'b1;
        target_value = base; adjustment_value = off;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_retired", {31'd0, retired}, 32'd0);
        check("rst_r5", registers[5], 32'd0);
        reset = 1'b0;
        tick();
        $display("[TB] reset released");

        // ALU write r5 with flags 1010
        alu(32'h100, 5'd5, 32'h12345678, 4'b1010);
        tick();
        idle_inputs();
        $display("[TB] alu r5 = %08h retired=%0b", registers[5], retired);
        check("alu_r5", registers[5], 32'h12345678);
        check("alu_flags", registers[30], 32'hA0000000);
        check("alu_retired", {31'd0, retired}, 32'd1);
        check("alu_retired_pc", retired_pc, 32'h100);
        tick();
        check("alu_retired_pulse", {31'd0, retired}, 32'd0);

        // r3 = DEADBEEF, flags 0101
        alu(32'h104, 5'd3, 32'hDEADBEEF, 4'b0101);
        tick();
        idle_inputs();
        $display("[TB] alu r3 = %08h", registers[3]);
        check("alu_r3", registers[3], 32'hDEADBEEF);
        check("alu_r3_flags", registers[30], 32'h50000000);

        // write to r0 dropped; flags still update
        alu(32'h108, 5'd0, 32'h00000055, 4'b0011);
        tick();
        idle_inputs();
        $display("[TB] alu r0 = %08h", registers[0]);
        check("r0_zero", registers[0], 32'd0);
        check("r0_flags", registers[30], 32'h30000000);

        // target = flags register: value wins over flags
        alu(32'h10C, FLAGS_INDEX, 32'h0, 4'b1111);
        tick();
        idle_inputs();
        $display("[TB] flags-index write = %08h", registers[30]);
        check("flags_index_wins", registers[30], 32'h0);

        // multiply into r31, upper goes to r0 (dropped)
        alu(32'h200, 5'd31, 32'h1, 4'b1100);
        has_upper_value = 1'b1;
        upper_value     = 32'hFFFF0000;
        tick();
        $display("[TB] mul r31 = %08h hold=%0b retired=%0b", registers[31], hold, retired);
        check("mul_r31", registers[31], 32'h1);
        check("mul_flags", registers[30], 32'hC0000000);
`ifdef WRITE_UPPER_EN
        check("mul_hold", {31'd0, hold}, 32'd1);
        check("mul_no_early_retire", {31'd0, retired}, 32'd0);
        upper_value = 32'h12121212;
        tick();
        check("mul_hold_released", {31'd0, hold}, 32'd0);
        idle_inputs();
        check("mul_retired", {31'd0, retired}, 32'd1);
        check("mul_retired_pc", retired_pc, 32'h200);
`else
        check("mul_hold", {31'd0, hold}, 32'd0);
        check("mul_retired", {31'd0, retired}, 32'd1);
        check("mul_retired_pc", retired_pc, 32'h200);
        idle_inputs();
`endif
        check("mul_r0", registers[0], 32'd0);
        check("mul_r1", registers[1], 32'd0);
        tick();
        check("mul_retired_pulse", {31'd0, retired}, 32'd0);

        // store r3 to 0xFFFFFFFC + 8, ready late
        store(32'h300, 5'd3, 32'hFFFFFFFC, 32'd8);
        tick();
        target_register = 5'd5; target_value = 32'h0; adjustment_value = 32'h0;
        for (int i = 0; i < 3; i++) begin
            $display("[TB] store wait %0d addr=%08h data=%08h hold=%0b", i, mem_address, mem_data, hold);
            check("st_mem_write", {31'd0, mem_write}, 32'd1);
            check("st_addr", mem_address, 32'h4);
            check("st_data", mem_data, 32'hDEADBEEF);
            check("st_hold", {31'd0, hold}, 32'd1);
            check("st_no_retire", {31'd0, retired}, 32'd0);
            if (i < 2) tick();
        end
        mem_ready = 1'b1;
        tick();
        check("st_done_write", {31'd0, mem_write}, 32'd0);
        check("st_retired", {31'd0, retired}, 32'd1);
        check("st_retired_pc", retired_pc, 32'h300);
        check("st_hold_released", {31'd0, hold}, 32'd0);
        idle_inputs();
        check("st_r3_kept", registers[3], 32'hDEADBEEF);
        check("st_flags_kept", registers[30], 32'hC0000000);
        tick();
        check("st_retired_pulse", {31'd0, retired}, 32'd0);

        // store with ready in first STORE cycle: 2-cycle latency
        store(32'h304, 5'd5, 32'h10, 32'h20);
        mem_ready = 1'b1;
        tick();
        $display("[TB] fast store addr=%08h data=%08h", mem_address, mem_data);
        check("fst_write", {31'd0, mem_write}, 32'd1);
        check("fst_addr", mem_address, 32'h30);
        check("fst_data", mem_data, 32'h12345678);
        is_valid = 1'b0;
        tick();
        check("fst_done", {31'd0, mem_write}, 32'd0);
        check("fst_retired", {31'd0, retired}, 32'd1);
        idle_inputs();
        tick();

        // flushed ALU and flushed store
        alu(32'h400, 5'd7, 32'h77, 4'b1111);
        has_flushed = 1'b1;
        tick();
        $display("[TB] flushed alu r7=%08h retired=%0b", registers[7], retired);
        check("fl_r7", registers[7], 32'd0);
        check("fl_flags", registers[30], 32'hC0000000);
        check("fl_retired", {31'd0, retired}, 32'd0);
        store(32'h404, 5'd3, 32'h40, 32'h0);
        has_flushed = 1'b1;
        tick();
        $display("[TB] flushed store mem_write=%0b", mem_write);
        check("fls_mem_write", {31'd0, mem_write}, 32'd0);
        check("fls_retired", {31'd0, retired}, 32'd0);
        check("fls_hold", {31'd0, hold}, 32'd0);
        idle_inputs();

        // reset mid-STORE
        store(32'h500, 5'd3, 32'h100, 32'h0);
        tick();
        check("rs_pre_write", {31'd0, mem_write}, 32'd1);
        #2 reset = 1'b1;
        #1;
        $display("[TB] reset mid-store mem_write=%0b r3=%08h", mem_write, registers[3]);
        check("rs_mem_write", {31'd0, mem_write}, 32'd0);
        check("rs_mem_addr", mem_address, 32'd0);
        check("rs_r3", registers[3], 32'd0);
        check("rs_r5", registers[5], 32'd0);
        check("rs_hold", {31'd0, hold}, 32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        check("rs_still_idle", {31'd0, mem_write}, 32'd0);
        alu(32'h600, 5'd9, 32'h99, 4'b0001);
        tick();
        idle_inputs();
        $display("[TB] post-reset alu r9=%08h", registers[9]);
        check("rs_next_r9", registers[9], 32'h99);
        check("rs_next_retired", {31'd0, retired}, 32'd1);
        check("rs_next_pc", retired_pc, 32'h600);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
